// File: rtl/rdwr_req_arb.sv
// Weighted read/write request arbiter onto a single registered TX issue bus.
// Optional statistics counters are built only when RDWR_ARB_STATS_EN is defined.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  RD_TURN | reads own the bus until RdWeight grants or reads stall
//  WR_TURN | writes own the bus until WrWeight packets or writes stall
//  WR_LOCK | mid multi-CL write packet; only its remaining beats issue
module rdwr_req_arb #(
    parameter int ADDR_LMT    = 20,
    parameter int MAX_RD_PEND = 512,
    parameter int PEND_W      = 10
) (
    input  logic                Clk_400,
    input  logic                SoftReset,
    input  logic [3:0]          cfg_RdWeight,
    input  logic [3:0]          cfg_WrWeight,
    input  logic                rw2ab_RdEn,
    input  logic [ADDR_LMT-1:0] rw2ab_RdAddr,
    input  logic [15:0]         rw2ab_RdTID,
    input  logic [1:0]          rw2ab_RdLen,
    output logic                ab2rw_RdSent,
    input  logic                rw2ab_WrEn,
    input  logic [ADDR_LMT-1:0] rw2ab_WrAddr,
    input  logic [15:0]         rw2ab_WrTID,
    input  logic [511:0]        rw2ab_WrDin,
    input  logic [1:0]          rw2ab_WrLen,
    input  logic                rw2ab_WrSop,
    output logic                ab2rw_WrSent,
    output logic                ab2rw_WrAlmFull,
    input  logic                tx2ab_AlmFull,
    input  logic                tx2ab_RdRspValid,
    output logic                ab2tx_Valid,
    output logic                ab2tx_IsWr,
    output logic [ADDR_LMT-1:0] ab2tx_Addr,
    output logic [15:0]         ab2tx_TID,
    output logic [1:0]          ab2tx_Len,
    output logic                ab2tx_Sop,
    output logic [511:0]        ab2tx_Data,
    output logic                ab2re_PendErr,
    output logic [31:0]         ab2re_RdGrants,
    output logic [31:0]         ab2re_WrGrants,
    output logic [31:0]         ab2re_StallCyc
);

    typedef enum logic [1:0] {
        RD_TURN = 2'd0,
        WR_TURN = 2'd1,
        WR_LOCK = 2'd2
    } state_t;

    localparam logic [PEND_W:0]   PEND_LIM = MAX_RD_PEND[PEND_W:0];
    localparam logic [PEND_W:0]   ONE_X    = {{PEND_W{1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] ONE_P    = {{(PEND_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [3:0]        count, count_nxt;
    logic [4:0]        count_inc;
    logic [1:0]        lock_cnt, lock_cnt_nxt;
    logic [4:0]        rd_weight, wr_weight;
    logic [PEND_W-1:0] rd_pend, pend_sum, pend_nxt;
    logic [PEND_W:0]   rd_need;
    logic              rd_ok, wr_ok, grant_rd, grant_wr, rsp_ok;

    assign rd_weight = (cfg_RdWeight == 4'd0) ? 5'd1 : {1'b0, cfg_RdWeight};
    assign wr_weight = (cfg_WrWeight == 4'd0) ? 5'd1 : {1'b0, cfg_WrWeight};
    assign count_inc = {1'b0, count} + 5'd1;

    // CLs that would be outstanding if this read were issued now
    assign rd_need = {1'b0, rd_pend} + {{(PEND_W-1){1'b0}}, rw2ab_RdLen} + ONE_X;

    assign rd_ok = rw2ab_RdEn & ~tx2ab_AlmFull & (rd_need <= PEND_LIM);
    assign wr_ok = rw2ab_WrEn & ~tx2ab_AlmFull;

    assign ab2rw_RdSent    = grant_rd;
    assign ab2rw_WrSent    = grant_wr;
    assign ab2rw_WrAlmFull = tx2ab_AlmFull;

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        lock_cnt_nxt = lock_cnt;
        grant_rd     = 1'b0;
        grant_wr     = 1'b0;
        if (!SoftReset) begin
            case (state)
                RD_TURN: begin
                    if (rd_ok) begin
                        grant_rd = 1'b1;
                        if (count_inc >= rd_weight) begin
                            state_nxt = WR_TURN;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count_inc[3:0];
                        end
                    end else if (wr_ok) begin
                        state_nxt = WR_TURN;
                        count_nxt = '0;
                    end
                end
                WR_TURN: begin
                    if (wr_ok) begin
                        grant_wr = 1'b1;
                        if (rw2ab_WrSop && (rw2ab_WrLen != 2'd0)) begin
                            state_nxt    = WR_LOCK;
                            lock_cnt_nxt = rw2ab_WrLen;
                        end else if (count_inc >= wr_weight) begin
                            state_nxt = RD_TURN;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count_inc[3:0];
                        end
                    end else if (rd_ok) begin
                        state_nxt = RD_TURN;
                        count_nxt = '0;
                    end
                end
                WR_LOCK: begin
                    // the packet counts toward the write weight only once its last beat issues
                    if (wr_ok) begin
                        grant_wr     = 1'b1;
                        lock_cnt_nxt = lock_cnt - 2'd1;
                        if (lock_cnt == 2'd1) begin
                            if (count_inc >= wr_weight) begin
                                state_nxt = RD_TURN;
                                count_nxt = '0;
                            end else begin
                                state_nxt = WR_TURN;
                                count_nxt = count_inc[3:0];
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = RD_TURN;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // a response arriving with nothing outstanding is dropped and flagged
    assign rsp_ok   = tx2ab_RdRspValid & (rd_pend != '0);
    assign pend_sum = grant_rd ? rd_need[PEND_W-1:0] : rd_pend;
    assign pend_nxt = rsp_ok ? (pend_sum - ONE_P) : pend_sum;

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            state         <= RD_TURN;
            count         <= '0;
            lock_cnt      <= '0;
            rd_pend       <= '0;
            ab2re_PendErr <= 1'b0;
            ab2tx_Valid   <= 1'b0;
            ab2tx_IsWr    <= 1'b0;
            ab2tx_Addr    <= '0;
            ab2tx_TID     <= '0;
            ab2tx_Len     <= '0;
            ab2tx_Sop     <= 1'b0;
            ab2tx_Data    <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            lock_cnt    <= lock_cnt_nxt;
            rd_pend     <= pend_nxt;
            ab2tx_Valid <= grant_rd | grant_wr;
            if (tx2ab_RdRspValid && (rd_pend == '0)) begin
                ab2re_PendErr <= 1'b1;
            end
            if (grant_wr) begin
                ab2tx_IsWr <= 1'b1;
                ab2tx_Addr <= rw2ab_WrAddr;
                ab2tx_TID  <= rw2ab_WrTID;
                ab2tx_Len  <= rw2ab_WrLen;
                ab2tx_Sop  <= rw2ab_WrSop;
                ab2tx_Data <= rw2ab_WrDin;
            end else if (grant_rd) begin
                ab2tx_IsWr <= 1'b0;
                ab2tx_Addr <= rw2ab_RdAddr;
                ab2tx_TID  <= rw2ab_RdTID;
                ab2tx_Len  <= rw2ab_RdLen;
                ab2tx_Sop  <= 1'b1;
                ab2tx_Data <= '0;
            end
        end
    end

`ifdef RDWR_ARB_STATS_EN
    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            ab2re_RdGrants <= '0;
            ab2re_WrGrants <= '0;
            ab2re_StallCyc <= '0;
        end else begin
            if (grant_rd) begin
                ab2re_RdGrants <= ab2re_RdGrants + 32'd1;
            end
            if (grant_wr) begin
                ab2re_WrGrants <= ab2re_WrGrants + 32'd1;
            end
            if ((rw2ab_RdEn | rw2ab_WrEn) & tx2ab_AlmFull) begin
                ab2re_StallCyc <= ab2re_StallCyc + 32'd1;
            end
        end
    end
`else
    assign ab2re_RdGrants = '0;
    assign ab2re_WrGrants = '0;
    assign ab2re_StallCyc = '0;
`endif

endmodule

// File: tb/tb_rdwr_req_arb.sv
// Randomized and directed bench for rdwr_req_arb against a turn-based reference model.
module tb_rdwr_req_arb;
    localparam int ADDR_LMT    = 20;
    localparam int MAX_RD_PEND = 4;
    localparam int PEND_W      = 3;
`ifdef RDWR_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                Clk_400 = 1'b0;
    logic                SoftReset;
    logic [3:0]          cfg_RdWeight, cfg_WrWeight;
    logic                rw2ab_RdEn, rw2ab_WrEn, rw2ab_WrSop;
    logic [ADDR_LMT-1:0] rw2ab_RdAddr, rw2ab_WrAddr;
    logic [15:0]         rw2ab_RdTID, rw2ab_WrTID;
    logic [1:0]          rw2ab_RdLen, rw2ab_WrLen;
    logic [511:0]        rw2ab_WrDin;
    logic                ab2rw_RdSent, ab2rw_WrSent, ab2rw_WrAlmFull;
    logic                tx2ab_AlmFull, tx2ab_RdRspValid;
    logic                ab2tx_Valid, ab2tx_IsWr, ab2tx_Sop;
    logic [ADDR_LMT-1:0] ab2tx_Addr;
    logic [15:0]         ab2tx_TID;
    logic [1:0]          ab2tx_Len;
    logic [511:0]        ab2tx_Data;
    logic                ab2re_PendErr;
    logic [31:0]         ab2re_RdGrants, ab2re_WrGrants, ab2re_StallCyc;

    rdwr_req_arb #(.ADDR_LMT(ADDR_LMT), .MAX_RD_PEND(MAX_RD_PEND), .PEND_W(PEND_W)) dut (
        .Clk_400(Clk_400), .SoftReset(SoftReset),
        .cfg_RdWeight(cfg_RdWeight), .cfg_WrWeight(cfg_WrWeight),
        .rw2ab_RdEn(rw2ab_RdEn), .rw2ab_RdAddr(rw2ab_RdAddr), .rw2ab_RdTID(rw2ab_RdTID),
        .rw2ab_RdLen(rw2ab_RdLen), .ab2rw_RdSent(ab2rw_RdSent),
        .rw2ab_WrEn(rw2ab_WrEn), .rw2ab_WrAddr(rw2ab_WrAddr), .rw2ab_WrTID(rw2ab_WrTID),
        .rw2ab_WrDin(rw2ab_WrDin), .rw2ab_WrLen(rw2ab_WrLen), .rw2ab_WrSop(rw2ab_WrSop),
        .ab2rw_WrSent(ab2rw_WrSent), .ab2rw_WrAlmFull(ab2rw_WrAlmFull),
        .tx2ab_AlmFull(tx2ab_AlmFull), .tx2ab_RdRspValid(tx2ab_RdRspValid),
        .ab2tx_Valid(ab2tx_Valid), .ab2tx_IsWr(ab2tx_IsWr), .ab2tx_Addr(ab2tx_Addr),
        .ab2tx_TID(ab2tx_TID), .ab2tx_Len(ab2tx_Len), .ab2tx_Sop(ab2tx_Sop),
        .ab2tx_Data(ab2tx_Data), .ab2re_PendErr(ab2re_PendErr),
        .ab2re_RdGrants(ab2re_RdGrants), .ab2re_WrGrants(ab2re_WrGrants),
        .ab2re_StallCyc(ab2re_StallCyc)
    );

    always #5 Clk_400 = ~Clk_400;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: whose turn it is, packets/grants done this turn, beats left in a locked packet
    int                  m_turn;   // 0 read, 1 write, 2 write packet in progress
    int                  m_cnt, m_lock, m_pend;
    bit                  m_err;
    logic [31:0]         m_rdg, m_wrg, m_stall;
    bit                  e_valid, e_iswr, e_sop;
    logic [ADDR_LMT-1:0] e_addr;
    logic [15:0]         e_tid;
    logic [1:0]          e_len;
    logic [511:0]        e_data;
    bit                  last_rs, last_ws, obs_rs, obs_ws;
    int                  wr_rem;

    function automatic void model_reset();
        m_turn = 0; m_cnt = 0; m_lock = 0; m_pend = 0; m_err = 1'b0;
        m_rdg = '0; m_wrg = '0; m_stall = '0;
        e_valid = 1'b0; e_iswr = 1'b0; e_sop = 1'b0;
        e_addr = '0; e_tid = '0; e_len = '0; e_data = '0;
        last_rs = 1'b0; last_ws = 1'b0;
    endfunction

    task automatic cycle();
        bit rd_ok, wr_ok, rs, ws, dec;
        int rw, ww;
        @(negedge Clk_400);
        rw = (cfg_RdWeight == 0) ? 1 : int'(cfg_RdWeight);
        ww = (cfg_WrWeight == 0) ? 1 : int'(cfg_WrWeight);
        rd_ok = rw2ab_RdEn && !tx2ab_AlmFull && (m_pend + int'(rw2ab_RdLen) + 1 <= MAX_RD_PEND);
        wr_ok = rw2ab_WrEn && !tx2ab_AlmFull;
        rs = !SoftReset && (m_turn == 0) && rd_ok;
        ws = !SoftReset && (m_turn != 0) && wr_ok;
        obs_rs = ab2rw_RdSent;
        obs_ws = ab2rw_WrSent;
        chk("rd_sent", ab2rw_RdSent, rs);
        chk("wr_sent", ab2rw_WrSent, ws);
        chk("almfull_pass", ab2rw_WrAlmFull, tx2ab_AlmFull);
        chk("tx_valid", ab2tx_Valid, e_valid);
        if (e_valid) begin
            chk("tx_iswr", ab2tx_IsWr, e_iswr);
            chk("tx_addr", ab2tx_Addr, e_addr);
            chk("tx_tid", ab2tx_TID, e_tid);
            chk("tx_len", ab2tx_Len, e_len);
            chk("tx_sop", ab2tx_Sop, e_sop);
            if (e_iswr) chk("tx_data", ab2tx_Data, e_data);
        end
        chk("pend_err", ab2re_PendErr, m_err);
        chk("rd_pend", dut.rd_pend, m_pend);
        chk("rd_grants", ab2re_RdGrants, STATS ? m_rdg : 32'd0);
        chk("wr_grants", ab2re_WrGrants, STATS ? m_wrg : 32'd0);
        chk("stall_cyc", ab2re_StallCyc, STATS ? m_stall : 32'd0);

        if (SoftReset) begin
            model_reset();
        end else begin
            case (m_turn)
                0: begin
                    if (rs) begin
                        m_cnt++;
                        if (m_cnt >= rw) begin m_turn = 1; m_cnt = 0; end
                    end else if (wr_ok) begin
                        m_turn = 1; m_cnt = 0;
                    end
                end
                1: begin
                    if (ws) begin
                        if (rw2ab_WrSop && rw2ab_WrLen != 0) begin
                            m_turn = 2; m_lock = int'(rw2ab_WrLen);
                        end else begin
                            m_cnt++;
                            if (m_cnt >= ww) begin m_turn = 0; m_cnt = 0; end
                        end
                    end else if (rd_ok) begin
                        m_turn = 0; m_cnt = 0;
                    end
                end
                default: begin
                    if (ws) begin
                        m_lock--;
                        if (m_lock == 0) begin
                            m_cnt++;
                            if (m_cnt >= ww) begin m_turn = 0; m_cnt = 0; end
                            else m_turn = 1;
                        end
                    end
                end
            endcase
            if (tx2ab_RdRspValid && m_pend == 0) m_err = 1'b1;
            dec = tx2ab_RdRspValid && (m_pend > 0);
            m_pend = m_pend + (rs ? int'(rw2ab_RdLen) + 1 : 0) - (dec ? 1 : 0);
            if (rs) m_rdg++;
            if (ws) m_wrg++;
            if ((rw2ab_RdEn || rw2ab_WrEn) && tx2ab_AlmFull) m_stall++;
            e_valid = rs || ws;
            if (ws) begin
                e_iswr = 1'b1; e_addr = rw2ab_WrAddr; e_tid = rw2ab_WrTID;
                e_len = rw2ab_WrLen; e_sop = rw2ab_WrSop; e_data = rw2ab_WrDin;
            end else if (rs) begin
                e_iswr = 1'b0; e_addr = rw2ab_RdAddr; e_tid = rw2ab_RdTID;
                e_len = rw2ab_RdLen; e_sop = 1'b1;
            end
            last_rs = rs;
            last_ws = ws;
        end
        @(posedge Clk_400);
        #1;
    endtask

    task automatic set_idle();
        rw2ab_RdEn = 1'b0; rw2ab_WrEn = 1'b0; rw2ab_WrSop = 1'b0;
        rw2ab_RdLen = '0; rw2ab_WrLen = '0;
        rw2ab_RdAddr = ADDR_LMT'($urandom); rw2ab_WrAddr = ADDR_LMT'($urandom);
        rw2ab_RdTID = 16'($urandom); rw2ab_WrTID = 16'($urandom);
        for (int k = 0; k < 16; k++) rw2ab_WrDin[k*32 +: 32] = $urandom;
        tx2ab_AlmFull = 1'b0; tx2ab_RdRspValid = 1'b0;
        wr_rem = 0;
    endtask

    task automatic do_reset();
        SoftReset = 1'b1;
        cycle();
        SoftReset = 1'b0;
        chk("rst_valid", ab2tx_Valid, 1'b0);
        chk("rst_iswr", ab2tx_IsWr, 1'b0);
        chk("rst_addr", ab2tx_Addr, '0);
        chk("rst_tid", ab2tx_TID, '0);
        chk("rst_len", ab2tx_Len, '0);
        chk("rst_sop", ab2tx_Sop, 1'b0);
        chk("rst_data", ab2tx_Data, '0);
        chk("rst_pend_err", ab2re_PendErr, 1'b0);
        chk("rst_stall", ab2re_StallCyc, 32'd0);
    endtask

    task automatic drive_random();
        if (!rw2ab_RdEn || last_rs) begin
            rw2ab_RdEn   = ($urandom_range(0, 3) != 0);
            rw2ab_RdAddr = ADDR_LMT'($urandom);
            rw2ab_RdTID  = 16'($urandom);
            rw2ab_RdLen  = 2'($urandom_range(0, 3));
        end
        if (last_ws) begin
            wr_rem = int'(rw2ab_WrLen);
            rw2ab_WrEn = 1'b0;
        end
        if (!rw2ab_WrEn && $urandom_range(0, 3) != 0) begin
            rw2ab_WrEn   = 1'b1;
            rw2ab_WrAddr = ADDR_LMT'($urandom);
            rw2ab_WrTID  = 16'($urandom);
            for (int k = 0; k < 16; k++) rw2ab_WrDin[k*32 +: 32] = $urandom;
            if (wr_rem == 0) begin
                rw2ab_WrSop = 1'b1;
                rw2ab_WrLen = 2'($urandom_range(0, 3));
            end else begin
                rw2ab_WrSop = 1'b0;
                rw2ab_WrLen = 2'(wr_rem - 1);
            end
        end
        tx2ab_AlmFull    = ($urandom_range(0, 7) == 0);
        tx2ab_RdRspValid = (m_pend > 0) && ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        int rcnt, wcnt;
        logic [8:0] seq;

        SoftReset = 1'b1;
        cfg_RdWeight = 4'd1;
        cfg_WrWeight = 4'd1;
        set_idle();
        repeat (2) @(posedge Clk_400);
        #1;
        model_reset();
        SoftReset = 1'b0;
        do_reset();

        // 1: weights 2/1, both streams saturated -> R,R,W repeating
        cfg_RdWeight = 4'd2; cfg_WrWeight = 4'd1;
        rw2ab_RdEn = 1'b1; rw2ab_WrEn = 1'b1; rw2ab_WrSop = 1'b1;
        seq = '0;
        for (int i = 0; i < 9; i++) begin
            rw2ab_RdAddr = ADDR_LMT'($urandom); rw2ab_WrAddr = ADDR_LMT'($urandom);
            tx2ab_RdRspValid = (m_pend > 0);
            cycle();
            seq = {seq[7:0], obs_ws};
        end
        chk("t1_order", seq, 9'b001001001);
        chk("t1_valid", ab2tx_Valid, 1'b1);

        // 2: 4-beat write packet stays atomic while reads wait
        set_idle(); do_reset();
        cfg_RdWeight = 4'd1; cfg_WrWeight = 4'd1;
        rw2ab_RdEn = 1'b1; rw2ab_WrEn = 1'b1; rw2ab_WrSop = 1'b1; rw2ab_WrLen = 2'd3;
        cycle();
        chk("t2_lead_rd", obs_rs, 1'b1);
        rcnt = 0; wcnt = 0;
        for (int b = 0; b < 4; b++) begin
            rw2ab_WrSop = (b == 0);
            rw2ab_WrLen = 2'(3 - b);
            rw2ab_WrTID = 16'($urandom);
            cycle();
            rcnt += int'(obs_rs); wcnt += int'(obs_ws);
        end
        chk("t2_wr_beats", wcnt, 4);
        chk("t2_rd_held", rcnt, 0);
        rw2ab_WrEn = 1'b0;
        cycle();
        chk("t2_rd_after", obs_rs, 1'b1);

        // 3: credit limit of 4 CLs with 2-CL reads
        set_idle(); do_reset();
        cfg_RdWeight = 4'd15;
        rw2ab_RdEn = 1'b1; rw2ab_RdLen = 2'd1;
        rcnt = 0;
        for (int i = 0; i < 5; i++) begin cycle(); rcnt += int'(obs_rs); end
        chk("t3_two_grants", rcnt, 2);
        tx2ab_RdRspValid = 1'b1; cycle();
        tx2ab_RdRspValid = 1'b0; cycle();
        chk("t3_still_blocked", obs_rs, 1'b0);
        tx2ab_RdRspValid = 1'b1; cycle();
        tx2ab_RdRspValid = 1'b0; cycle();
        chk("t3_grant_after_2rsp", obs_rs, 1'b1);

        // 4: almost-full stalls both streams for 5 cycles
        set_idle(); do_reset();
        rw2ab_RdEn = 1'b1; rw2ab_WrEn = 1'b1; rw2ab_WrSop = 1'b1; tx2ab_AlmFull = 1'b1;
        rcnt = 0;
        for (int i = 0; i < 5; i++) begin cycle(); rcnt += int'(obs_rs) + int'(obs_ws); end
        chk("t4_no_sent", rcnt, 0);
        chk("t4_valid", ab2tx_Valid, 1'b0);
        chk("t4_stall", ab2re_StallCyc, STATS ? 32'd5 : 32'd0);

        // 5: grant and response in the same cycle, then response with nothing outstanding
        set_idle(); do_reset();
        cfg_RdWeight = 4'd15;
        rw2ab_RdEn = 1'b1; rw2ab_RdLen = 2'd1;
        cycle();
        tx2ab_RdRspValid = 1'b1;
        cycle();
        chk("t5_pend_sum", dut.rd_pend, 3);
        rw2ab_RdEn = 1'b0;
        repeat (3) cycle();
        cycle();
        chk("t5_pend_err", ab2re_PendErr, 1'b1);
        chk("t5_pend_zero", dut.rd_pend, 0);

        // 6: reset in the middle of a locked write packet
        set_idle(); do_reset();
        cfg_RdWeight = 4'd1; cfg_WrWeight = 4'd1;
        rw2ab_RdEn = 1'b1; rw2ab_WrEn = 1'b1; rw2ab_WrSop = 1'b1; rw2ab_WrLen = 2'd3;
        cycle();
        cycle();
        rw2ab_WrSop = 1'b0; rw2ab_WrLen = 2'd2;
        cycle();
        chk("t6_lock_beat", obs_ws, 1'b1);
        rw2ab_WrLen = 2'd1;
        do_reset();
        cycle();
        chk("t6_rd_first", obs_rs, 1'b1);
        chk("t6_no_wr", obs_ws, 1'b0);

        // random traffic with occasional weight changes and resets
        set_idle(); do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                cfg_RdWeight = 4'($urandom_range(0, 15));
                cfg_WrWeight = 4'($urandom_range(0, 15));
            end
            drive_random();
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
